dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder serving the MEM-stage load/store port of the pipelined CPU.
- The CPU side initiates word requests with a req/ready handshake; this block decodes, stalls for a programmable number of wait states, then answers with read data or a write commit.
- It supplies `busy` so the pipeline can freeze, and provides multi-cycle memory behaviour for the pipeline's stall logic.

Parameters:
- DEPTH_LOG2, 8, number of 32-bit words is 2**DEPTH_LOG2 (256 words = byte addresses 0x000-0x3FF).
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Clrn  input  1  asynchronous active-low reset.
- req  input  1  request valid; the initiator holds req, we, addr, wdata, be stable until it samples ready=1.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data.
- be  input  4  byte enables for stores; be[0] covers bits 7:0.
- ready  output  1  one-cycle response strobe.
- rdata  output  32  load data; valid only while ready=1, otherwise 0.
- err  output  1  asserted with ready when the request was rejected.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (Clrn=0, asynchronous):
  - State goes to IDLE; the wait counter clears.
  - ready=0, err=0, rdata=0, busy=0.
  - Memory contents are not cleared.
  - An in-flight request is dropped with no write; the initiator must reissue it.
- States:
  - IDLE: waiting for req.
  - WAIT: counting wait states.
  - RESP: ready asserted.
- Acceptance: on a rising edge in IDLE with req=1, latch we, addr, wdata, be.
- Address check at acceptance:
  - Error if addr[1:0]!=0 or addr[31:DEPTH_LOG2+2]!=0.
  - Error request: go to RESP immediately, regardless of LATENCY. err=1, ready=1, rdata=0, no memory access.
  - Valid request, LATENCY=0: go to RESP.
  - Valid request, LATENCY>0: go to WAIT with counter=LATENCY.
- WAIT: counter decrements each cycle; when the counter equals 1, go to RESP. ready is therefore high in the (LATENCY+1)th cycle after the acceptance edge.
- RESP (exactly one cycle):
  - ready=1.
  - Load: rdata = mem[addr[DEPTH_LOG2+1:2]].
  - Store: rdata = old contents (read-before-write). Bytes with be[i]=1 are written at the edge that ends RESP. be=0000 completes normally with no change.
  - Next state is always IDLE; req is ignored during RESP.
- Turnaround:
  - The initiator drops or changes req after the edge where it sees ready.
  - A new req present in IDLE is accepted at the next edge, giving a minimum of LATENCY+2 cycles per transaction.
- Stability: changes to req or address inputs while busy=1 are ignored; only the latched copy is used.
- busy is registered from state and is 1 in WAIT and RESP.
- ready, err and rdata are registered (glitch-free) and are never high outside RESP.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 0x10 with be=1111 (LATENCY=2): accepted at edge E0, busy=1 from E0, ready=1 and err=0 for exactly one cycle starting E0+3 cycles. A subsequent load of 0x10 returns rdata=0xDEADBEEF with ready 3 cycles after its acceptance.
- Store 0x0000AB00 to 0x10 with be=0010, then load 0x10: first response rdata=0xDEADBEEF (old value), second rdata=0xDEADABEF.
- Load from misaligned 0x12, then out-of-range 0x400: each gives ready=1, err=1, rdata=0 one cycle after acceptance (no wait states). A following load of 0x10 still returns 0xDEADABEF.
- Store 0x12345678 to 0x20, drop Clrn to 0 during WAIT for 30 ns, then release: ready never pulses, busy=0 immediately on Clrn low. A subsequent load of 0x20 returns the prior (unwritten) value.
- Back-to-back loads with req held high across ready for addrs 0x10 and 0x14: responses spaced LATENCY+2=4 cycles apart, each with a single ready pulse and no duplicate acceptance.
- Regression with LATENCY=0: store then load at 0x3FC with wdata=0xCAFEF00D. ready comes 1 cycle after acceptance and load rdata=0xCAFEF00D, confirming the top word boundary.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU MEM stage: accepts one word request at a time,
// inserts LATENCY wait states, then returns a one-cycle registered response.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    logic [31:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  busy_q, busy_d;

    logic                  addr_bad;
    logic [DEPTH_LOG2-1:0] addr_idx;

    // Rejected: misaligned, or any bit above the word array is set.
    assign addr_bad = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign addr_idx = addr[DEPTH_LOG2+1:2];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    idx_d   = addr_idx;
                    wdata_d = wdata;
                    be_d    = be;
                    if (addr_bad) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                    end else if (LATENCY == 0) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        rdata_d = mem[addr_idx];
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    rdata_d = mem[idx_q];
                end
                cnt_d = cnt_q - 4'd1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; contents survive Clrn.
    // Store commits on the edge that ends RESP, after rdata captured the old word.
    always_ff @(posedge Clk) begin
        if (state_q == S_RESP && we_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: edge-numbered transaction model plus
// directed literal checks; a second instance covers the zero-wait-state build.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Clrn = 1'b1;
    logic        req = 1'b0;
    logic        sel0 = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  be = 4'd0;

    logic        req_m, req_z;
    logic        ready, err, busy;
    logic [31:0] rdata;
    logic        ready0, err0, busy0;
    logic [31:0] rdata0;

    assign req_m = req & ~sel0;
    assign req_z = req & sel0;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) u_dut (
        .Clk(Clk), .Clrn(Clrn), .req(req_m), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready), .rdata(rdata), .err(err), .busy(busy)
    );

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(0)) u_dut0 (
        .Clk(Clk), .Clrn(Clrn), .req(req_z), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .ready(ready0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Transaction-level model: edges are numbered, each accepted request owns a
    // response edge; a store lands in the array one edge after its response.
    logic [31:0] m_mem [256];
    logic [3:0]  m_kn  [256];
    int          edge_n = 0;
    int          m_free = 0;
    int          m_resp = 0;
    bit          m_pend = 0;
    bit          m_we, m_bad;
    int          m_idx;
    logic [31:0] m_wd;
    logic [3:0]  m_be;
    bit          m_ready = 0, m_err = 0, m_busy = 0;
    logic [31:0] m_rdata = 32'd0;
    logic [31:0] m_mask = 32'hFFFF_FFFF;

    initial begin
        for (int i = 0; i < 256; i++) m_kn[i] = 4'd0;
    end

    always @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            m_pend  = 0;
            m_free  = 0;
            m_ready = 0;
            m_err   = 0;
            m_busy  = 0;
            m_rdata = 32'd0;
            m_mask  = 32'hFFFF_FFFF;
        end else begin
            edge_n++;
            if (m_pend && edge_n == m_resp + 1) begin
                if (m_we && !m_bad) begin
                    for (int b = 0; b < 4; b++) begin
                        if (m_be[b]) begin
                            m_mem[m_idx][8*b +: 8] = m_wd[8*b +: 8];
                            m_kn[m_idx][b] = 1'b1;
                        end
                    end
                end
                m_pend = 0;
            end
            if (!m_pend && edge_n >= m_free && req_m) begin
                m_we   = we;
                m_bad  = (addr % 4 != 0) || (addr >= 32'd1024);
                m_idx  = int'(addr[9:2]);
                m_wd   = wdata;
                m_be   = be;
                m_resp = edge_n + (m_bad ? 0 : LAT);
                m_free = m_resp + 2;
                m_pend = 1;
            end
            m_busy  = m_pend && edge_n <= m_resp;
            m_ready = m_pend && edge_n == m_resp;
            m_err   = m_ready && m_bad;
            m_rdata = 32'd0;
            m_mask  = 32'hFFFF_FFFF;
            if (m_ready && !m_bad) begin
                m_rdata = m_mem[m_idx];
                for (int b = 0; b < 4; b++) m_mask[8*b +: 8] = {8{m_kn[m_idx][b]}};
            end
        end
    end

    always @(negedge Clk) begin
        check("ready", {31'd0, ready}, {31'd0, m_ready});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("rdata", rdata & m_mask, m_rdata & m_mask);
    end

    task automatic txn(input bit sel, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, input bit keep,
                       output logic [31:0] rd, output bit er, output int lat, output time t_rdy);
        @(negedge Clk);
        sel0 = sel; req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
        end while (!(sel ? ready0 : ready) && lat < 40);
        if (!(sel ? ready0 : ready)) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout waiting for ready addr=%h", a);
        end
        rd    = sel ? rdata0 : rdata;
        er    = sel ? err0 : err;
        t_rdy = $time;
        if (!keep) req = 1'b0;
    endtask

    logic [31:0] rd, a;
    bit          er, bad;
    int          lat, k;
    time         t1, t2;

    initial begin
        #1 Clrn = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        #20 Clrn = 1'b1;

        txn(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, rd, er, lat, t1);
        check("st1_lat", lat, 32'd3);
        check("st1_err", {31'd0, er}, 32'd0);
        txn(0, 0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("ld1_rdata", rd, 32'hDEADBEEF);
        check("ld1_lat", lat, 32'd3);

        txn(0, 1, 32'h10, 32'h0000AB00, 4'b0010, 0, rd, er, lat, t1);
        check("st2_old", rd, 32'hDEADBEEF);
        txn(0, 0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("ld2_rdata", rd, 32'hDEADABEF);

        txn(0, 0, 32'h12, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("mis_err", {31'd0, er}, 32'd1);
        check("mis_rdata", rd, 32'd0);
        check("mis_lat", lat, 32'd1);
        txn(0, 0, 32'h400, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("oor_err", {31'd0, er}, 32'd1);
        check("oor_rdata", rd, 32'd0);
        check("oor_lat", lat, 32'd1);
        txn(0, 0, 32'h10, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("ld3_rdata", rd, 32'hDEADABEF);

        // Store interrupted by reset during its wait states must leave memory untouched.
        txn(0, 1, 32'h20, 32'h11111111, 4'b1111, 0, rd, er, lat, t1);
        @(negedge Clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; be = 4'b1111;
        @(negedge Clk);
        check("rstw_busy", {31'd0, busy}, 32'd1);
        #2 Clrn = 1'b0; req = 1'b0;
        #1;
        check("rstw_busy_low", {31'd0, busy}, 32'd0);
        check("rstw_ready_low", {31'd0, ready}, 32'd0);
        #27 Clrn = 1'b1;
        repeat (6) @(negedge Clk);
        txn(0, 0, 32'h20, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("rstw_rdata", rd, 32'h11111111);

        txn(0, 0, 32'h10, 32'h0, 4'b0000, 1, rd, er, lat, t1);
        check("b2b_rdata", rd, 32'hDEADABEF);
        txn(0, 0, 32'h14, 32'h0, 4'b0000, 0, rd, er, lat, t2);
        check("b2b_gap", 32'((t2 - t1) / 10), 32'd4);

        txn(1, 1, 32'h3FC, 32'hCAFEF00D, 4'b1111, 0, rd, er, lat, t1);
        check("l0_st_lat", lat, 32'd1);
        check("l0_st_err", {31'd0, er}, 32'd0);
        txn(1, 0, 32'h3FC, 32'h0, 4'b0000, 0, rd, er, lat, t1);
        check("l0_ld_rdata", rd, 32'hCAFEF00D);
        check("l0_ld_lat", lat, 32'd1);
        sel0 = 1'b0;

        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0) a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            else if (k == 1) a = ($urandom | 32'h400) & 32'hFFFF_FFFC;
            else if (k == 2) a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            else a = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            bad = (a[1:0] != 2'b00) || (a >= 32'd1024);
            txn(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 0, rd, er, lat, t1);
            check("rnd_lat", lat, bad ? 32'd1 : 32'(LAT + 1));
            check("rnd_err", {31'd0, er}, {31'd0, bad});
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        repeat (4) @(negedge Clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
